// File: rtl/i_decode_pkg.sv
// Shared definitions for the instruction-decode stage: word type, opcodes,
// ALUOp encodings and control-vector bit positions.
package i_decode_pkg;

    localparam int WORD_W = 32;
    localparam int RIDX_W = 5;
    localparam int CTRL_W = 9;

    typedef logic [WORD_W-1:0] word_t;

    // Main opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALUOp encodings consumed by the execute-stage ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control vector: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
    //                  MemWrite, Branch, ALUOp[1:0]}
    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // Sign-extend a 16-bit immediate to a full word
    function automatic word_t sign_extend16(input logic [15:0] imm);
        return {{(WORD_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/i_decode_reg_file.sv
// Register file: NREG x WORD storage with hardwired-zero r0, synchronous
// clear, and a write-through bypass so writeback data reaches the decode in
// the same cycle it is written.
module reg_file
    import i_decode_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [WORD_W-1:0] rd1,
    output logic [WORD_W-1:0] rd2,
    input  logic              we,
    input  logic [4:0]        wa,
    input  logic [WORD_W-1:0] wd
);

    logic [WORD_W-1:0] mem_q [NREG];
    logic              wr_ok;

    assign wr_ok = we && (wa != 5'd0);

    // Storage: cleared by reset, written on enabled non-zero index
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wa] <= wd;
        end
    end

    // Port 1 read: r0 is zero, a matching write bypasses the array
    always_comb begin
        rd1 = '0;
        if (ra1 != 5'd0) begin
            if (wr_ok && (wa == ra1)) begin
                rd1 = wd;
            end else begin
                rd1 = mem_q[ra1];
            end
        end
    end

    // Port 2 read: same rules as port 1
    always_comb begin
        rd2 = '0;
        if (ra2 != 5'd0) begin
            if (wr_ok && (wa == ra2)) begin
                rd2 = wd;
            end else begin
                rd2 = mem_q[ra2];
            end
        end
    end

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage: operand read, immediate sign extension and main
// control decode, all captured in the ID/EX latch with flush and stall.
module i_decode
    import i_decode_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] IR,
    input  logic [WORD_W-1:0] nPC,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [WORD_W-1:0] wb_data,
    output logic [WORD_W-1:0] ex_nPC,
    output logic [WORD_W-1:0] ex_rd1,
    output logic [WORD_W-1:0] ex_rd2,
    output logic [WORD_W-1:0] ex_imm,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [5:0]        ex_funct,
    output logic [8:0]        ex_ctrl,
    output logic              ex_illegal
);

    logic [5:0]        opcode;
    logic [4:0]        rs_idx;
    logic [4:0]        rt_idx;
    logic [WORD_W-1:0] rd1_d;
    logic [WORD_W-1:0] rd2_d;
    logic [WORD_W-1:0] imm_d;
    logic [8:0]        ctrl_d;
    logic              illegal_d;

    logic [WORD_W-1:0] npc_q;
    logic [WORD_W-1:0] rd1_q;
    logic [WORD_W-1:0] rd2_q;
    logic [WORD_W-1:0] imm_q;
    logic [4:0]        rt_q;
    logic [4:0]        rd_q;
    logic [5:0]        funct_q;
    logic [8:0]        ctrl_q;
    logic              illegal_q;

    assign opcode = IR[31:26];
    assign rs_idx = IR[25:21];
    assign rt_idx = IR[20:16];
    assign imm_d  = sign_extend16(IR[15:0]);

    reg_file #(
        .NREG (NREG)
    ) u_reg_file (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs_idx),
        .ra2   (rt_idx),
        .rd1   (rd1_d),
        .rd2   (rd2_d),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // Main control decode; unknown opcodes produce an all-zero vector
    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d[CTRL_REGDST]                   = 1'b1;
                ctrl_d[CTRL_REGWRITE]                 = 1'b1;
                ctrl_d[CTRL_ALUOP_HI:CTRL_ALUOP_LO]   = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_d[CTRL_ALUSRC]                   = 1'b1;
                ctrl_d[CTRL_MEMTOREG]                 = 1'b1;
                ctrl_d[CTRL_REGWRITE]                 = 1'b1;
                ctrl_d[CTRL_MEMREAD]                  = 1'b1;
                ctrl_d[CTRL_ALUOP_HI:CTRL_ALUOP_LO]   = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl_d[CTRL_ALUSRC]                   = 1'b1;
                ctrl_d[CTRL_MEMWRITE]                 = 1'b1;
                ctrl_d[CTRL_ALUOP_HI:CTRL_ALUOP_LO]   = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl_d[CTRL_BRANCH]                   = 1'b1;
                ctrl_d[CTRL_ALUOP_HI:CTRL_ALUOP_LO]   = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_d[CTRL_ALUSRC]                   = 1'b1;
                ctrl_d[CTRL_REGWRITE]                 = 1'b1;
                ctrl_d[CTRL_ALUOP_HI:CTRL_ALUOP_LO]   = ALUOP_ADD;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // ID/EX latch: reset, then flush (bubble beats stall), then stall, then load
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            npc_q     <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            imm_q     <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            funct_q   <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            npc_q     <= nPC;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            rt_q      <= rt_idx;
            rd_q      <= IR[15:11];
            funct_q   <= IR[5:0];
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_nPC     = npc_q;
    assign ex_rd1     = rd1_q;
    assign ex_rd2     = rd2_q;
    assign ex_imm     = imm_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_funct   = funct_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_illegal = illegal_q;

endmodule

// File: tb/tb_i_decode.sv
// Self-checking bench for i_decode: directed scenarios followed by random
// traffic, compared against a behavioural register/latch model.
module tb_i_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR, nPC, wb_data;
    logic        stall, flush, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] ex_nPC, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic [8:0]  ex_ctrl;
    logic        ex_illegal;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] e_npc, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rt, e_rd;
    logic [5:0]  e_funct;
    logic [8:0]  e_ctrl;
    logic        e_ill;

    always #5 clk = ~clk;

    i_decode #(.NREG(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .nPC        (nPC),
        .stall      (stall),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_nPC     (ex_nPC),
        .ex_rd1     (ex_rd1),
        .ex_rd2     (ex_rd2),
        .ex_imm     (ex_imm),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .ex_funct   (ex_funct),
        .ex_ctrl    (ex_ctrl),
        .ex_illegal (ex_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control word assembled from named fields, per opcode meaning
    function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
        logic regdst, alusrc, m2r, regw, memr, memw, br, ill;
        logic [1:0] aluop;
        {regdst, alusrc, m2r, regw, memr, memw, br, ill} = '0;
        aluop = 2'b00;
        if (op == 6'h00)      begin regdst = 1; regw = 1; aluop = 2'b10; end
        else if (op == 6'h23) begin alusrc = 1; m2r = 1; regw = 1; memr = 1; end
        else if (op == 6'h2B) begin alusrc = 1; memw = 1; end
        else if (op == 6'h04) begin br = 1; aluop = 2'b01; end
        else if (op == 6'h08) begin alusrc = 1; regw = 1; end
        else ill = 1;
        return {ill, regdst, alusrc, m2r, regw, memr, memw, br, aluop};
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (we && wa == idx) return wd;
        return m_regs[idx];
    endfunction

    // One clock: drive inputs, advance the model, check after the edge
    task automatic step(input logic rst, input logic [31:0] ir, input logic [31:0] npc,
                        input logic stl, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
        logic [9:0] c;
        reset = rst; IR = ir; nPC = npc; stall = stl; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        if (!rst || fl) begin
            {e_npc, e_rd1, e_rd2, e_imm} = '0;
            {e_rt, e_rd, e_funct, e_ctrl, e_ill} = '0;
        end else if (!stl) begin
            c       = ref_ctrl(ir[31:26]);
            e_npc   = npc;
            e_rd1   = ref_read(ir[25:21], we, wa, wd);
            e_rd2   = ref_read(ir[20:16], we, wa, wd);
            e_imm   = 32'($signed(ir[15:0]));
            e_rt    = ir[20:16];
            e_rd    = ir[15:11];
            e_funct = ir[5:0];
            e_ctrl  = c[8:0];
            e_ill   = c[9];
        end
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else if (we && wa != 0) begin
            m_regs[wa] = wd;
        end
        @(posedge clk);
        #1;
        chk("ex_nPC",     ex_nPC,             e_npc);
        chk("ex_rd1",     ex_rd1,             e_rd1);
        chk("ex_rd2",     ex_rd2,             e_rd2);
        chk("ex_imm",     ex_imm,             e_imm);
        chk("ex_rt",      {27'h0, ex_rt},     {27'h0, e_rt});
        chk("ex_rd",      {27'h0, ex_rd},     {27'h0, e_rd});
        chk("ex_funct",   {26'h0, ex_funct},  {26'h0, e_funct});
        chk("ex_ctrl",    {23'h0, ex_ctrl},   {23'h0, e_ctrl});
        chk("ex_illegal", {31'h0, ex_illegal}, {31'h0, e_ill});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ir_r, held_rd1;
        logic [5:0]  op;
        logic [5:0]  ops [5];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;

        // Reset for two cycles; a writeback during reset must be discarded
        step(0, 32'h8C220004, 32'h4, 0, 0, 1, 5'd5, 32'h55555555);
        step(0, 32'h8C220004, 32'h4, 0, 0, 0, 5'd0, 32'h0);
        chk("reset_ctrl", {23'h0, ex_ctrl}, 32'h0);
        // r5 read after reset: rs=5
        step(1, 32'h00A00000, 32'h5, 0, 0, 0, 5'd0, 32'h0);
        chk("r5_after_reset", ex_rd1, 32'h0);

        // Write r3 and read it via the bypass in the same cycle (add $1,$3,$3)
        step(1, 32'h00630820, 32'h6, 0, 0, 1, 5'd3, 32'hDEADBEEF);
        chk("bypass_rd1", ex_rd1, 32'hDEADBEEF);
        chk("bypass_rd2", ex_rd2, 32'hDEADBEEF);
        // And through the array in the next cycle
        step(1, 32'h00630820, 32'h7, 0, 0, 0, 5'd0, 32'h0);
        chk("array_rd1", ex_rd1, 32'hDEADBEEF);

        // lw decode
        step(1, 32'h8C22FFFC, 32'h10, 0, 0, 0, 5'd0, 32'h0);
        chk("lw_ctrl", {23'h0, ex_ctrl}, 32'h0F0);
        chk("lw_imm",  ex_imm, 32'hFFFFFFFC);
        chk("lw_npc",  ex_nPC, 32'h10);

        // Register 0: write attempt with read in the same cycle, then later
        step(1, 32'h00000000, 32'h11, 0, 0, 1, 5'd0, 32'h1234);
        chk("r0_bypass", ex_rd1, 32'h0);
        step(1, 32'h00000000, 32'h12, 0, 0, 0, 5'd0, 32'h0);
        chk("r0_read", ex_rd2, 32'h0);

        // Stall 3 cycles with a writeback to r7 during the stall
        step(1, 32'h00E31020, 32'h20, 0, 0, 0, 5'd0, 32'h0);
        held_rd1 = ex_rd1;
        step(1, 32'h12345678, 32'h21, 1, 0, 1, 5'd7, 32'hCAFEF00D);
        step(1, 32'h12345678, 32'h22, 1, 0, 0, 5'd0, 32'h0);
        step(1, 32'h12345678, 32'h23, 1, 0, 0, 5'd0, 32'h0);
        chk("stall_npc", ex_nPC, 32'h20);
        // Flush together with stall -> bubble
        step(1, 32'h12345678, 32'h24, 1, 1, 0, 5'd0, 32'h0);
        chk("flush_npc", ex_nPC, 32'h0);
        // Stall-time write committed: read r7 (rs=7)
        step(1, 32'h00E31020, 32'h25, 0, 0, 0, 5'd0, 32'h0);
        chk("stall_write", ex_rd1, 32'hCAFEF00D);

        // Illegal opcode
        step(1, 32'hFC000000, 32'h30, 0, 0, 0, 5'd0, 32'h0);
        chk("illegal_flag", {31'h0, ex_illegal}, 32'h1);
        chk("illegal_ctrl", {23'h0, ex_ctrl}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)];
            ir_r = {op, 26'($urandom)};
            step(($urandom_range(0, 39) != 0), ir_r, $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 2) == 0) ? ir_r[25:21] : 5'($urandom),
                 $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
